// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer for the equal-precision frequency meter.
// Clears the counter bank and opens a gate that starts and ends on synchronised
// rising edges of fx_in. It then reports completion with done_sig and holds off
// the next run until the MCU has finished reading a frame.
module freq_meas_ctrl #(
   parameter int unsigned GATE_CYCLES    = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned DONE_CYCLES    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       fx_in,
   input  logic       spi_cs_n,
   output logic       cnt_clr,
   output logic       gate,
   output logic       done_sig,
   output logic       timeout,
   output logic       busy,
   output logic [7:0] meas_id
);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StArm,
      StGate,
      StClose,
      StSettle,
      StDone,
      StWaitSend
   } state_e;

   state_e      state;
   logic [31:0] cnt;

   logic fx_s1, fx_s2, fx_h;
   logic cs_s1, cs_s2, cs_h;
   logic fx_rise, cs_rise;

   // Two-flop synchronisers plus a history flop per asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fx_s1 <= 1'b0;
         fx_s2 <= 1'b0;
         fx_h  <= 1'b0;
         cs_s1 <= 1'b0;
         cs_s2 <= 1'b0;
         cs_h  <= 1'b0;
      end else begin
         fx_s1 <= fx_in;
         fx_s2 <= fx_s1;
         fx_h  <= fx_s2;
         cs_s1 <= spi_cs_n;
         cs_s2 <= cs_s1;
         cs_h  <= cs_s2;
      end
   end

   assign fx_rise = fx_s2 & ~fx_h;
   assign cs_rise = cs_s2 & ~cs_h;

   // Sequencer state, shared phase counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         cnt      <= 32'd0;
         cnt_clr  <= 1'b0;
         gate     <= 1'b0;
         done_sig <= 1'b0;
         timeout  <= 1'b0;
         busy     <= 1'b0;
         meas_id  <= 8'd0;
      end else begin
         cnt_clr <= 1'b0;
         unique case (state)
            StIdle: begin
               if (enable) begin
                  state   <= StClear;
                  cnt_clr <= 1'b1;
                  timeout <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            StClear: begin
               state <= StArm;
               cnt   <= 32'd0;
            end
            StArm: begin
               // An edge wins over a coincident timeout.
               if (fx_rise) begin
                  state <= StGate;
                  gate  <= 1'b1;
                  cnt   <= 32'd0;
               end else if (cnt == TIMEOUT_CYCLES - 1) begin
                  state   <= StSettle;
                  timeout <= 1'b1;
                  cnt     <= 32'd0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StGate: begin
               // fx edges are deliberately ignored for the whole minimum gate.
               if (cnt == GATE_CYCLES - 1) begin
                  state <= StClose;
                  cnt   <= 32'd0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StClose: begin
               if (fx_rise) begin
                  state <= StSettle;
                  gate  <= 1'b0;
                  cnt   <= 32'd0;
               end else if (cnt == TIMEOUT_CYCLES - 1) begin
                  state   <= StSettle;
                  gate    <= 1'b0;
                  timeout <= 1'b1;
                  cnt     <= 32'd0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StSettle: begin
               if (cnt == SETTLE_CYCLES - 1) begin
                  state    <= StDone;
                  done_sig <= 1'b1;
                  meas_id  <= meas_id + 8'd1;
                  cnt      <= 32'd0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StDone: begin
               if (cnt == DONE_CYCLES - 1) begin
                  state    <= StWaitSend;
                  done_sig <= 1'b0;
                  busy     <= 1'b0;
                  cnt      <= 32'd0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            StWaitSend: begin
               // A finished frame read takes priority over a dropped enable.
               if (cs_rise) begin
                  if (enable) begin
                     state   <= StClear;
                     cnt_clr <= 1'b1;
                     timeout <= 1'b0;
                     busy    <= 1'b1;
                  end else begin
                     state <= StIdle;
                  end
               end else if (!enable) begin
                  state <= StIdle;
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: a phase/deadline reference model is
// compared against the DUT every cycle, plus directed timing checks.
module tb_freq_meas_ctrl;

   localparam int unsigned G = 100;
   localparam int unsigned T = 50;
   localparam int unsigned S = 4;
   localparam int unsigned D = 4;

   localparam int PH_IDLE   = 0;
   localparam int PH_CLEAR  = 1;
   localparam int PH_ARM    = 2;
   localparam int PH_GATE   = 3;
   localparam int PH_CLOSE  = 4;
   localparam int PH_SETTLE = 5;
   localparam int PH_DONE   = 6;
   localparam int PH_WAIT   = 7;

   localparam int O_GATE = 0;
   localparam int O_DONE = 1;
   localparam int O_CLR  = 2;
   localparam int O_TMO  = 3;
   localparam int O_BUSY = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       fx_in = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       cnt_clr, gate, done_sig, timeout, busy;
   logic [7:0] meas_id;

   int checks = 0;
   int fails = 0;
   int cyc = 0;

   // reference model state
   int         ph = PH_IDLE;
   int         t0 = 0;
   logic       m_tmo = 1'b0;
   logic [7:0] m_id = 8'd0;
   logic       fx_d1 = 1'b0, fx_d2 = 1'b0, fx_d3 = 1'b0;
   logic       cs_d1 = 1'b0, cs_d2 = 1'b0, cs_d3 = 1'b0;

   // stimulus / monitor state
   int   fx_per = 7;
   int   t_clr = 0, t_gate_rise = 0, t_gate_fall = 0;
   int   t_done_rise = 0, t_done_fall = 0, t_tmo_rise = 0;
   int   n_clr = 0, n_gate_rise = 0;
   logic p_clr = 1'b0, p_gate = 1'b0, p_done = 1'b0, p_tmo = 1'b0;

   freq_meas_ctrl #(
      .GATE_CYCLES   (G),
      .TIMEOUT_CYCLES(T),
      .SETTLE_CYCLES (S),
      .DONE_CYCLES   (D)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .fx_in   (fx_in),
      .spi_cs_n(spi_cs_n),
      .cnt_clr (cnt_clr),
      .gate    (gate),
      .done_sig(done_sig),
      .timeout (timeout),
      .busy    (busy),
      .meas_id (meas_id)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic out_bit(input int which);
      case (which)
         O_GATE:  return gate;
         O_DONE:  return done_sig;
         O_CLR:   return cnt_clr;
         O_TMO:   return timeout;
         O_BUSY:  return busy;
         default: return 1'bx;
      endcase
   endfunction

   // Wait at negedges until an output reaches a value; expiry counts as a failure.
   task automatic wait_out(input int which, input logic val, input int budget, input string name);
      int n;
      n = 0;
      while (out_bit(which) !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({"wait_", name}, {31'd0, out_bit(which)}, {31'd0, val});
   endtask

   task automatic model_reset();
      ph    = PH_IDLE;
      t0    = cyc;
      m_tmo = 1'b0;
      m_id  = 8'd0;
      fx_d1 = 1'b0; fx_d2 = 1'b0; fx_d3 = 1'b0;
      cs_d1 = 1'b0; cs_d2 = 1'b0; cs_d3 = 1'b0;
   endtask

   task automatic go(input int p);
      ph = p;
      t0 = cyc;
   endtask

   // One clock edge of the reference: phases end by elapsed cycle count or by a
   // pin edge that has had two clocks to pass through synchronisation.
   task automatic model_step();
      logic fxr, csr;
      int   el;
      fxr   = fx_d2 & ~fx_d3;
      csr   = cs_d2 & ~cs_d3;
      fx_d3 = fx_d2; fx_d2 = fx_d1; fx_d1 = fx_in;
      cs_d3 = cs_d2; cs_d2 = cs_d1; cs_d1 = spi_cs_n;
      el = cyc - t0;
      case (ph)
         PH_IDLE: if (enable) begin m_tmo = 1'b0; go(PH_CLEAR); end
         PH_CLEAR: go(PH_ARM);
         PH_ARM: begin
            if (fxr) go(PH_GATE);
            else if (el == int'(T)) begin m_tmo = 1'b1; go(PH_SETTLE); end
         end
         PH_GATE: if (el == int'(G)) go(PH_CLOSE);
         PH_CLOSE: begin
            if (fxr) go(PH_SETTLE);
            else if (el == int'(T)) begin m_tmo = 1'b1; go(PH_SETTLE); end
         end
         PH_SETTLE: if (el == int'(S)) begin m_id = m_id + 8'd1; go(PH_DONE); end
         PH_DONE: if (el == int'(D)) go(PH_WAIT);
         default: begin
            if (csr) begin
               if (enable) begin m_tmo = 1'b0; go(PH_CLEAR); end
               else go(PH_IDLE);
            end else if (!enable) go(PH_IDLE);
         end
      endcase
   endtask

   // Model advance on every clock edge, reset immediately on rst_n assertion.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            cyc++;
            model_step();
         end
      end
   end

   // Per-cycle comparison against the model, plus edge timestamps for directed checks.
   initial begin
      logic e_clr, e_gate, e_done, e_busy;
      forever begin
         @(posedge clk);
         #3;
         e_clr  = (ph == PH_CLEAR);
         e_gate = (ph == PH_GATE) || (ph == PH_CLOSE);
         e_done = (ph == PH_DONE);
         e_busy = !((ph == PH_IDLE) || (ph == PH_WAIT));
         check("outputs_vs_model",
               {19'd0, cnt_clr, gate, done_sig, timeout, busy, meas_id},
               {19'd0, e_clr, e_gate, e_done, m_tmo, e_busy, m_id});
         if (cnt_clr && !p_clr) begin t_clr = cyc; n_clr++; end
         if (gate && !p_gate) begin t_gate_rise = cyc; n_gate_rise++; end
         if (!gate && p_gate) t_gate_fall = cyc;
         if (done_sig && !p_done) t_done_rise = cyc;
         if (!done_sig && p_done) t_done_fall = cyc;
         if (timeout && !p_tmo) t_tmo_rise = cyc;
         p_clr = cnt_clr; p_gate = gate; p_done = done_sig; p_tmo = timeout;
      end
   end

   // Signal under test: period fx_per clocks, fx_per == 0 holds it low.
   initial begin
      int fx_ph;
      fx_ph = 0;
      forever begin
         @(negedge clk);
         if (fx_per == 0) fx_in = 1'b0;
         else begin
            fx_ph = (fx_ph + 1) % fx_per;
            fx_in = (fx_ph < fx_per / 2);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   // MCU frame read: chip select low for three clocks then released.
   task automatic frame_read();
      spi_cs_n = 1'b0;
      repeat (3) @(negedge clk);
      spi_cs_n = 1'b1;
   endtask

   initial begin
      int m, nb, gb, act;
      // reset state
      repeat (3) @(negedge clk);
      check("rst_cnt_clr", {31'd0, cnt_clr}, 32'd0);
      check("rst_gate", {31'd0, gate}, 32'd0);
      check("rst_done", {31'd0, done_sig}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_meas_id", {24'd0, meas_id}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // nominal measurement
      enable = 1'b1;
      wait_out(O_GATE, 1'b1, 200, "nom_gate_rise");
      wait_out(O_GATE, 1'b0, 300, "nom_gate_fall");
      wait_out(O_DONE, 1'b1, 50, "nom_done_rise");
      wait_out(O_DONE, 1'b0, 50, "nom_done_fall");
      check("nom_gate_width_101_108",
            {31'd0, (t_gate_fall - t_gate_rise >= 101) && (t_gate_fall - t_gate_rise <= 108)}, 32'd1);
      check("nom_done_after_gate", t_done_rise - t_gate_fall, S);
      check("nom_done_width", t_done_fall - t_done_rise, D);
      check("nom_meas_id", {24'd0, meas_id}, 32'd1);
      check("nom_one_clear", n_clr, 32'd1);

      // holdoff without chip-select activity
      nb = n_clr;
      repeat (1000) @(negedge clk);
      check("hold_no_clear", n_clr, nb);
      check("hold_busy", {31'd0, busy}, 32'd0);
      frame_read();
      m = cyc;
      wait_out(O_CLR, 1'b1, 10, "hold_release_clr");
      // pin released in cycle m, clear pulse visible in cycle m+3
      check("hold_clr_latency", t_clr - m, 32'd3);

      // chip-select pulse during the gate is ignored
      wait_out(O_GATE, 1'b1, 200, "csg_gate_rise");
      repeat (20) @(negedge clk);
      frame_read();
      nb = n_clr;
      wait_out(O_DONE, 1'b1, 300, "csg_done_rise");
      wait_out(O_DONE, 1'b0, 20, "csg_done_fall");
      check("csg_meas_id", {24'd0, meas_id}, 32'd2);
      repeat (30) @(negedge clk);
      check("csg_no_release", n_clr, nb);
      check("csg_busy", {31'd0, busy}, 32'd0);

      // no signal: ARM timeout
      fx_per = 0;
      repeat (10) @(negedge clk);
      gb = n_gate_rise;
      frame_read();
      wait_out(O_CLR, 1'b1, 10, "nosig_clr");
      wait_out(O_TMO, 1'b1, 100, "nosig_timeout");
      check("nosig_timeout_time", t_tmo_rise - t_clr, T + 1);
      wait_out(O_DONE, 1'b1, 20, "nosig_done_rise");
      wait_out(O_DONE, 1'b0, 20, "nosig_done_fall");
      check("nosig_no_gate", n_gate_rise, gb);
      check("nosig_meas_id", {24'd0, meas_id}, 32'd3);
      check("nosig_timeout_held", {31'd0, timeout}, 32'd1);
      fx_per = 5;
      repeat (10) @(negedge clk);
      frame_read();
      wait_out(O_CLR, 1'b1, 10, "stop_clr");
      check("timeout_cleared_by_clr", {31'd0, timeout}, 32'd0);

      // fx stops mid-gate: CLOSE timeout
      wait_out(O_GATE, 1'b1, 200, "stop_gate_rise");
      repeat (80) @(negedge clk);
      fx_per = 0;
      wait_out(O_GATE, 1'b0, 200, "stop_gate_fall");
      check("stop_gate_width", t_gate_fall - t_gate_rise, G + T);
      check("stop_timeout", {31'd0, timeout}, 32'd1);
      wait_out(O_DONE, 1'b1, 20, "stop_done_rise");
      check("stop_done_after_gate", t_done_rise - t_gate_fall, S);
      wait_out(O_DONE, 1'b0, 20, "stop_done_fall");
      check("stop_meas_id", {24'd0, meas_id}, 32'd4);

      // enable dropped during the gate
      fx_per = 7;
      repeat (10) @(negedge clk);
      frame_read();
      wait_out(O_GATE, 1'b1, 200, "drop_gate_rise");
      enable = 1'b0;
      wait_out(O_DONE, 1'b1, 300, "drop_done_rise");
      wait_out(O_DONE, 1'b0, 20, "drop_done_fall");
      check("drop_meas_id", {24'd0, meas_id}, 32'd5);
      nb = n_clr;
      repeat (300) @(negedge clk);
      check("drop_meas_id_stable", {24'd0, meas_id}, 32'd5);
      check("drop_no_clear", n_clr, nb);
      check("drop_busy", {31'd0, busy}, 32'd0);

      // reset in the middle of a gate
      enable = 1'b1;
      wait_out(O_GATE, 1'b1, 200, "rstg_gate_rise");
      repeat (10) @(negedge clk);
      #5 rst_n = 1'b0;
      #1;
      check("rstg_gate", {31'd0, gate}, 32'd0);
      check("rstg_busy", {31'd0, busy}, 32'd0);
      check("rstg_timeout", {31'd0, timeout}, 32'd0);
      check("rstg_done", {31'd0, done_sig}, 32'd0);
      check("rstg_cnt_clr", {31'd0, cnt_clr}, 32'd0);
      check("rstg_meas_id", {24'd0, meas_id}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstg_clr_after_release", {31'd0, cnt_clr}, 32'd1);
      wait_out(O_DONE, 1'b1, 400, "rstg_done_rise");
      wait_out(O_DONE, 1'b0, 20, "rstg_done_fall");
      check("rstg_meas_id_after", {24'd0, meas_id}, 32'd1);

      // randomized runs, checked by the per-cycle model
      for (int i = 0; i < 12; i++) begin
         enable = 1'b1;
         fx_per = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(3, 15));
         repeat (5) @(negedge clk);
         if (!busy) frame_read();
         repeat ($urandom_range(0, 200)) @(negedge clk);
         act = int'($urandom_range(0, 3));
         case (act)
            1: fx_per = 0;
            2: frame_read();
            3: enable = 1'b0;
            default: ;
         endcase
         wait_out(O_BUSY, 1'b0, 600, "rand_idle");
         repeat ($urandom_range(1, 20)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
